// File: rtl/frame_unpacker_100m.sv
// Receive-side deframer: hunts for SYNC, assembles {CNT, DATA, CRC} frames from a serial
// bit stream, checks CRC-8 and counter continuity, and presents good payloads.
module frame_unpacker_100m #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter logic [7:0]  CRC_POLY    = 8'h07,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,
  input  logic        rx_bit_i,
  input  logic        rx_bit_valid_i,
  output logic [31:0] dout_o,
  output logic [7:0]  dout_cnt_o,
  output logic        dout_valid_o,
  output logic        crc_err_o,
  output logic        seq_err_o,
  output logic        sync_lost_o,
  output logic        locked_o,
  output logic [7:0]  frame_count_o,
  output logic [7:0]  err_count_o
);
  localparam int unsigned FRAME_W = 48;
  localparam int unsigned BCNT_W  = 6;
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RUN_W   = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_SYNC} state_e;

  state_e              state_q, state_d;
  logic [6:0]          win_q, win_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0]  frame_q, frame_d;
  logic [FRAME_W-1:0]  hold_q, hold_d;
  logic                check_req_q, check_req_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                have_prev_q, have_prev_d;
  logic [7:0]          last_cnt_q, last_cnt_d;
  logic [31:0]         dout_q, dout_d;
  logic [7:0]          dout_cnt_q, dout_cnt_d;
  logic                dout_valid_q, dout_valid_d;
  logic                crc_err_q, crc_err_d;
  logic                seq_err_q, seq_err_d;
  logic                sync_lost_q, sync_lost_d;
  logic                locked_q, locked_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [7:0]          shifted;
  logic [FRAME_W-1:0]  frame_shift;
  logic                sync_miss, timeout, good, bad;
  logic [7:0]          crc_calc, next_cnt;
  logic [8:0]          err_sum;

  // MSB-first CRC-8, init 0, no reflection, no final XOR
  function automatic logic [7:0] crc8(input logic [39:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    check_req_d = 1'b0;
    idle_d      = '0;
    sync_miss   = 1'b0;
    timeout     = 1'b0;
    shifted     = {win_q, rx_bit_i};
    frame_shift = {frame_q, rx_bit_i};

    unique case (state_q)
      ST_HUNT: begin
        if (rx_bit_valid_i) begin
          win_d = shifted[6:0];
          if (shifted == SYNC_BYTE) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (rx_bit_valid_i) begin
          frame_d = frame_shift[FRAME_W-2:0];
          if (bit_cnt_q == BCNT_W'(FRAME_W - 1)) begin
            hold_d      = frame_shift;
            check_req_d = 1'b1;
            state_d     = ST_SYNC;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end else begin
          idle_d  = idle_q + IDLE_W'(1);
          timeout = (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
        end
      end
      ST_SYNC: begin
        if (rx_bit_valid_i) begin
          win_d = shifted[6:0];
          if (bit_cnt_q == BCNT_W'(7)) begin
            bit_cnt_d = '0;
            if (shifted == SYNC_BYTE) begin
              state_d = ST_DATA;
            end else begin
              sync_miss = 1'b1;
              state_d   = ST_HUNT;
              win_d     = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end else if (bit_cnt_q != '0) begin
          // Gaps before the first sync bit are legal inter-frame idle
          idle_d  = idle_q + IDLE_W'(1);
          timeout = (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
        end
      end
      default: state_d = ST_HUNT;
    endcase

    if (timeout) begin
      state_d   = ST_HUNT;
      win_d     = '0;
      bit_cnt_d = '0;
      idle_d    = '0;
    end

    crc_calc = crc8(hold_q[47:8]);
    good     = check_req_q && (crc_calc == hold_q[7:0]);
    bad      = check_req_q && (crc_calc != hold_q[7:0]);
    next_cnt = last_cnt_q + 8'd1;

    // A failed CRC overrides whatever the FSM decided this cycle
    if (bad) begin
      state_d     = ST_HUNT;
      win_d       = '0;
      bit_cnt_d   = '0;
      idle_d      = '0;
      check_req_d = 1'b0;
    end

    dout_d        = good ? hold_q[39:8]  : dout_q;
    dout_cnt_d    = good ? hold_q[47:40] : dout_cnt_q;
    last_cnt_d    = good ? hold_q[47:40] : last_cnt_q;
    dout_valid_d  = good;
    crc_err_d     = bad;
    seq_err_d     = good && have_prev_q && (hold_q[47:40] != next_cnt);
    sync_lost_d   = sync_miss || timeout;
    frame_count_d = frame_count_q + 8'(good);

    have_prev_d = have_prev_q;
    if (good)           have_prev_d = 1'b1;
    if (bad || timeout) have_prev_d = 1'b0;

    run_d    = run_q;
    locked_d = locked_q;
    if (good) begin
      if (run_q != RUN_W'(LOCK_FRAMES)) run_d = run_q + RUN_W'(1);
      if (run_d == RUN_W'(LOCK_FRAMES)) locked_d = 1'b1;
    end
    if (bad || sync_lost_d) begin
      run_d    = '0;
      locked_d = 1'b0;
    end

    err_sum     = 9'(err_count_q) + 9'(crc_err_d) + 9'(sync_lost_d);
    err_count_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q       <= ST_HUNT;
      win_q         <= '0;
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      hold_q        <= '0;
      check_req_q   <= 1'b0;
      idle_q        <= '0;
      run_q         <= '0;
      have_prev_q   <= 1'b0;
      last_cnt_q    <= '0;
      dout_q        <= '0;
      dout_cnt_q    <= '0;
      dout_valid_q  <= 1'b0;
      crc_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      sync_lost_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      hold_q        <= hold_d;
      check_req_q   <= check_req_d;
      idle_q        <= idle_d;
      run_q         <= run_d;
      have_prev_q   <= have_prev_d;
      last_cnt_q    <= last_cnt_d;
      dout_q        <= dout_d;
      dout_cnt_q    <= dout_cnt_d;
      dout_valid_q  <= dout_valid_d;
      crc_err_q     <= crc_err_d;
      seq_err_q     <= seq_err_d;
      sync_lost_q   <= sync_lost_d;
      locked_q      <= locked_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign dout_o        = dout_q;
  assign dout_cnt_o    = dout_cnt_q;
  assign dout_valid_o  = dout_valid_q;
  assign crc_err_o     = crc_err_q;
  assign seq_err_o     = seq_err_q;
  assign sync_lost_o   = sync_lost_q;
  assign locked_o      = locked_q;
  assign frame_count_o = frame_count_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_frame_unpacker_100m.sv
// Bench for frame_unpacker_100m: drives serial frames, scoreboards delivered payloads
// against queued expectations and checks status outputs after each scenario.
module tb_frame_unpacker_100m;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  cnt;
    logic        seq;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_bit = 1'b0;
  logic        rx_bit_valid = 1'b0;
  logic [31:0] dout;
  logic [7:0]  dout_cnt;
  logic        dout_valid, crc_err, seq_err, sync_lost, locked;
  logic [7:0]  frame_count, err_count;

  int   checks = 0;
  int   errors = 0;
  obs_t obs_q[$];
  obs_t exp_q[$];
  int   obs_rd = 0;
  int   n_crc = 0;
  int   n_sync = 0;

  frame_unpacker_100m dut (
    .clk_sys_i      (clk),
    .rst_i          (rst),
    .rx_bit_i       (rx_bit),
    .rx_bit_valid_i (rx_bit_valid),
    .dout_o         (dout),
    .dout_cnt_o     (dout_cnt),
    .dout_valid_o   (dout_valid),
    .crc_err_o      (crc_err),
    .seq_err_o      (seq_err),
    .sync_lost_o    (sync_lost),
    .locked_o       (locked),
    .frame_count_o  (frame_count),
    .err_count_o    (err_count)
  );

  always #5 clk = ~clk;

  // Record delivered frames and error pulses away from the active edge
  always @(negedge clk) begin
    if (!rst && dout_valid) obs_q.push_back({dout, dout_cnt, seq_err});
    if (!rst && crc_err)    n_crc++;
    if (!rst && sync_lost)  n_sync++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Byte-wise reference CRC-8 (poly 0x07, init 0, MSB first)
  function automatic logic [7:0] crc8_model(input logic [39:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 4; b >= 0; b--) begin
      c = c ^ d[8*b +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    rx_bit = b;
    rx_bit_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_bit_valid = 1'b0;
    rx_bit = 1'b0;
    if (gap > 0) idle(gap);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_frame(input logic [7:0] cnt, input logic [31:0] data,
                            input logic [7:0] crc, input int gap);
    send_byte(8'hAA, gap);
    send_byte(cnt, gap);
    for (int k = 3; k >= 0; k--) send_byte(data[8*k +: 8], gap);
    send_byte(crc, gap);
  endtask

  task automatic good_frame(input logic [7:0] cnt, input logic [31:0] data,
                            input logic seq, input int gap);
    exp_q.push_back({data, cnt, seq});
    send_frame(cnt, data, crc8_model({cnt, data}), gap);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    checks++;
    if ((|{dout, dout_cnt}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: dout=%h dout_cnt=%h, required 0", dout, dout_cnt);
    end
    checks++;
    if ((|{dout_valid, crc_err, seq_err, sync_lost, locked}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: v=%b c=%b s=%b l=%b k=%b, required 0",
               dout_valid, crc_err, seq_err, sync_lost, locked);
    end
    checks++;
    if ((|{frame_count, err_count}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_counts: frame_count=%0d err_count=%0d, required 0", frame_count, err_count);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_acq;
    obs_t o, e;
    send_byte(8'h00, 0);
    exp_q.push_back({32'h0, 8'h00, 1'b0});
    send_frame(8'h00, 32'h0, 8'h00, 0);
    exp_q.push_back({32'h0, 8'h01, 1'b0});
    send_frame(8'h01, 32'h0, 8'h62, 0);
    idle(4);
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL clean_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clean_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    checks++;
    if (frame_count !== 8'd2) begin
      errors++; $display("FAIL clean_frame_count: got %0d, required 2", frame_count);
    end
    checks++;
    if (err_count !== 8'd0 || n_crc != 0 || n_sync != 0) begin
      errors++;
      $display("FAIL clean_no_err: err_count=%0d crc=%0d sync=%0d, required 0", err_count, n_crc, n_sync);
    end
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL clean_locked: got %b after 2 frames, required 0", locked);
    end
  endtask

  task automatic test_crc_error;
    int c0, s0, f0;
    c0 = n_crc; f0 = obs_q.size();
    send_frame(8'h01, 32'h0, 8'h63, 0);
    idle(4);
    checks++;
    if (n_crc - c0 != 1) begin
      errors++; $display("FAIL crc_pulse: got %0d crc_err pulses, required 1", n_crc - c0);
    end
    checks++;
    if (err_count !== 8'd1) begin
      errors++; $display("FAIL crc_err_count: got %0d, required 1", err_count);
    end
    checks++;
    if (obs_q.size() != f0 || dout_cnt !== 8'h01) begin
      errors++;
      $display("FAIL crc_no_deliver: new frames=%0d dout_cnt=%h, required 0 and 01", obs_q.size() - f0, dout_cnt);
    end
    obs_rd = obs_q.size();
    // In HUNT a non-sync byte is simply shifted; in SYNC it would raise sync_lost
    s0 = n_sync;
    send_byte(8'h00, 0);
    idle(3);
    checks++;
    if (n_sync != s0) begin
      errors++; $display("FAIL crc_to_hunt: got %0d sync_lost pulses, required 0", n_sync - s0);
    end
  endtask

  task automatic test_lock_seq;
    obs_t o, e;
    good_frame(8'h00, $urandom, 1'b0, 3);
    good_frame(8'h01, $urandom, 1'b0, 3);
    idle(4);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL lock_early: locked=%b after 2 frames, required 0", locked);
    end
    good_frame(8'h02, $urandom, 1'b0, 3);
    idle(4);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_set: locked=%b after 3 frames, required 1", locked);
    end
    good_frame(8'h05, $urandom, 1'b1, 3);
    idle(4);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold_seq: locked=%b after seq error, required 1", locked);
    end
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL lock_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lock_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    checks++;
    if (frame_count !== 8'd6) begin
      errors++; $display("FAIL lock_frame_count: got %0d, required 6", frame_count);
    end
  endtask

  task automatic test_sync_loss;
    obs_t o, e;
    int s0;
    s0 = n_sync;
    send_byte(8'hAB, 3);
    idle(2);
    checks++;
    if (n_sync - s0 != 1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL sync_lost: pulses=%0d locked=%b, required 1 and 0", n_sync - s0, locked);
    end
    checks++;
    if (err_count !== 8'd2) begin
      errors++; $display("FAIL sync_err_count: got %0d, required 2", err_count);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h00, 1);
    good_frame(8'h06, $urandom, 1'b0, 3);
    idle(4);
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL sync_reacq_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sync_reacq_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
  endtask

  task automatic test_timeout;
    obs_t o, e;
    int s0;
    s0 = n_sync;
    send_byte(8'hAA, 0);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0);
    idle(62);
    checks++;
    if (n_sync != s0) begin
      errors++; $display("FAIL timeout_early: sync_lost after 62 idle cycles, required none");
    end
    idle(4);
    checks++;
    if (n_sync - s0 != 1 || err_count !== 8'd3) begin
      errors++;
      $display("FAIL timeout_fire: pulses=%0d err_count=%0d, required 1 and 3", n_sync - s0, err_count);
    end
    send_byte(8'h00, 0);
    good_frame(8'h09, $urandom, 1'b0, 3);
    idle(4);
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    checks++;
    if (frame_count !== 8'd8) begin
      errors++; $display("FAIL timeout_frame_count: got %0d, required 8", frame_count);
    end
  endtask

  task automatic test_reset_mid;
    obs_t o, e;
    send_byte(8'hAA, 0);
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ((|{dout, dout_cnt, dout_valid, crc_err, seq_err, sync_lost, locked, frame_count, err_count}) !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: dout=%h cnt=%h fc=%0d ec=%0d locked=%b, required all 0",
               dout, dout_cnt, frame_count, err_count, locked);
    end
    obs_rd = obs_q.size();
    send_byte(8'h00, 0);
    good_frame(8'h03, $urandom, 1'b0, 3);
    idle(4);
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    checks++;
    if (frame_count !== 8'd1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_counts: fc=%0d ec=%0d, required 1 and 0", frame_count, err_count);
    end
  endtask

  task automatic test_back_to_back;
    obs_t o, e;
    int c0, s0;
    good_frame(8'h04, $urandom, 1'b0, 0);
    good_frame(8'h05, $urandom, 1'b0, 0);
    good_frame(8'h06, $urandom, 1'b0, 0);
    idle(4);
    checks++;
    if (locked !== 1'b1 || frame_count !== 8'd4) begin
      errors++;
      $display("FAIL b2b_lock: locked=%b fc=%0d, required 1 and 4", locked, frame_count);
    end
    // Bad frame immediately followed by a frame whose first sync bit meets the CRC verdict
    c0 = n_crc; s0 = n_sync;
    send_frame(8'h07, 32'h1234_5678, crc8_model({8'h07, 32'h1234_5678}) ^ 8'h01, 0);
    send_frame(8'h10, 32'h0, crc8_model({8'h10, 32'h0}), 0);
    send_byte(8'h00, 0);
    good_frame(8'h11, $urandom, 1'b0, 0);
    idle(4);
    checks++;
    if (n_crc - c0 != 1 || n_sync != s0) begin
      errors++;
      $display("FAIL b2b_crc: crc pulses=%0d sync pulses=%0d, required 1 and 0", n_crc - c0, n_sync - s0);
    end
    checks++;
    if (obs_q.size() - obs_rd != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d frames, required %0d", obs_q.size() - obs_rd, exp_q.size());
    end
    while (obs_rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[obs_rd]; obs_rd++; e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_frame: got %h/%h/%b, required %h/%h/%b", o.data, o.cnt, o.seq, e.data, e.cnt, e.seq);
      end
    end
    obs_rd = obs_q.size(); exp_q.delete();
    checks++;
    if (frame_count !== 8'd5 || err_count !== 8'd1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL b2b_status: fc=%0d ec=%0d locked=%b, required 5, 1, 0", frame_count, err_count, locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_acq();
    test_crc_error();
    test_lock_seq();
    test_sync_loss();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
